mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256, number of 64-bit doublewords in the backing store.
REQ-002 Parameter WAIT, default 2, wait-state cycles inserted between request acceptance and access (0 legal).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 MemRead  input  1  load request from datapath.
REQ-006 MemWrite  input  1  store request from datapath.
REQ-007 address  input  64  byte address.
REQ-008 writedata  input  64  store data, right-justified.
REQ-009 funct3  input  3  access size/sign (RISC-V load/store funct3).
REQ-010 readdata  output  64  load result, sign/zero-extended.
REQ-011 ready  output  1  one-cycle response strobe.
REQ-012 busy  output  1  high while a request is in flight (datapath stalls on it).
REQ-013 fault  output  1  qualifies ready: request rejected, no memory effect.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; requests sampled only in IDLE; MemRead/MemWrite ignored in ACCESS and RESP.
REQ-015 IDLE: at a rising edge with MemRead or MemWrite high, latch address, writedata, funct3, op; go ACCESS with wait counter = WAIT, or RESP directly if WAIT = 0.
REQ-016 ACCESS: counter decrements each cycle; at the edge where it reads 0, perform access, go RESP.
REQ-017 With WAIT = 0, access performed on the acceptance edge.
REQ-018 RESP: ready = 1 for exactly one cycle, then IDLE; ready = 0 in all other states.
REQ-019 Latency: ready high in cycle WAIT+1 after acceptance edge; back-to-back requests accepted no earlier than the IDLE cycle after RESP.
REQ-020 busy = 1 in ACCESS and RESP, 0 in IDLE.
REQ-021 Size: funct3 000/100 byte, 001/101 half, 010/110 word, 011 double; 000-011 sign-extend loads, 100-110 zero-extend; 111 illegal.
REQ-022 Doubleword index = address[log2(DEPTH)+2:3]; byte lane = address[2:0]; little-endian lane order.
REQ-023 Fault when: MemRead and MemWrite both high; funct3 = 111; address not size-aligned; address >= DEPTH*8; or MemWrite with funct3 100-110.
REQ-024 Faulting request follows the same FSM and latency, asserts fault with ready in RESP, does not modify storage, does not change readdata.
REQ-025 Store modifies only the addressed byte lanes (read-modify-write of one doubleword); other lanes unchanged.
REQ-026 Load updates readdata on the access edge; readdata holds its value until the next successful load completes.
REQ-027 Store completion leaves readdata unchanged.
REQ-028 fault is 0 on non-faulting RESP cycles and outside RESP.

Reset
REQ-029 rst low at a rising edge: state IDLE, counter 0, ready 0, busy 0, fault 0, readdata 0.
REQ-030 Reset mid-ACCESS aborts the request: no storage write; no ready issued.
REQ-031 Storage contents are not cleared by reset.

Verification
REQ-032 WAIT=2: SD addr 0x10 data 0x1122334455667788 funct3 011, then LD addr 0x10 -> ready 3 cycles after each acceptance, readdata 0x1122334455667788, busy high 3 cycles per request.
REQ-033 After REQ-032: SB addr 0x13 data 0xAB, then LB 0x13 -> 0xFFFFFFFFFFFFFFAB; LBU 0x13 -> 0x00000000000000AB; LD 0x10 -> 0x11223344AB667788.
REQ-034 LW addr 0x12 (misaligned) -> ready+fault in RESP, readdata unchanged; SW addr 0x800 with DEPTH=256 -> fault, storage unchanged.
REQ-035 MemRead and MemWrite both high -> fault; MemWrite held high during ACCESS/RESP -> exactly one store, one ready.
REQ-036 rst low during ACCESS of SD 0x20 data 0xFF -> no ready, busy 0 next cycle, subsequent LD 0x20 returns prior contents.
REQ-037 WAIT=0: LH addr 0x16 holding 0x8001 -> ready cycle after acceptance, readdata 0xFFFFFFFFFFFF8001.

Source files
------------

// File: rtl/mem_ctrl.sv
// Wait-stated doubleword memory controller for a RISC-V datapath.
// Accepts one load/store at a time in IDLE, checks it for faults, and answers with a one-cycle ready strobe.
module mem_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] address,
  input  logic [63:0] writedata,
  input  logic [2:0]  funct3,
  output logic [63:0] readdata,
  output logic        ready,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned IW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(WAIT + 2);
  localparam logic [63:0] LIMIT  = 64'(DEPTH) * 64'd8;
  localparam bit          DIRECT = (WAIT == 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_addr, r_wdata;
  logic [2:0]    r_f3;
  logic          r_rd, r_wr, r_flt;
  logic [63:0]   r_mem [DEPTH];

  logic          w_req, w_accept, w_size_bad, w_req_flt, w_cnt_done, w_acc;
  logic          w_ready_nxt, w_busy_nxt, w_fault_nxt;
  logic [63:0]   w_a_addr, w_a_wdata;
  logic [2:0]    w_a_f3;
  logic          w_a_rd, w_a_wr, w_a_flt, w_ld_en, w_st_en;
  logic [IW-1:0] w_idx;
  logic [5:0]    w_sh;
  logic [63:0]   w_old, w_lane, w_ld_val, w_smask, w_bmask, w_new;

  assign w_req      = MemRead | MemWrite;
  assign w_accept   = (r_state == IDLE) & w_req;
  assign w_cnt_done = (r_cnt <= CW'(1));

  // Fault classification of the request currently on the inputs
  always_comb begin
    w_size_bad = 1'b0;
    case (funct3[1:0])
      2'b01:   w_size_bad = address[0];
      2'b10:   w_size_bad = |address[1:0];
      2'b11:   w_size_bad = |address[2:0];
      default: w_size_bad = 1'b0;
    endcase
    w_req_flt = (MemRead & MemWrite) | (funct3 == 3'b111) | w_size_bad |
                (address >= LIMIT) | (MemWrite & funct3[2]);
  end

  // With no wait states the access uses the live request, otherwise the latched one
  assign w_a_addr  = DIRECT ? address   : r_addr;
  assign w_a_wdata = DIRECT ? writedata : r_wdata;
  assign w_a_f3    = DIRECT ? funct3    : r_f3;
  assign w_a_rd    = DIRECT ? MemRead   : r_rd;
  assign w_a_wr    = DIRECT ? MemWrite  : r_wr;
  assign w_a_flt   = DIRECT ? w_req_flt : r_flt;
  assign w_acc     = DIRECT ? w_accept  : ((r_state == ACCESS) & w_cnt_done);
  assign w_ld_en   = rst & w_acc & w_a_rd & ~w_a_flt;
  assign w_st_en   = rst & w_acc & w_a_wr & ~w_a_flt;

  assign w_idx  = w_a_addr[IW+2:3];
  assign w_sh   = {w_a_addr[2:0], 3'b000};
  assign w_old  = r_mem[w_idx];
  assign w_lane = w_old >> w_sh;

  // Lane extraction with sign/zero extension, and the read-modify-write merge
  always_comb begin
    case (w_a_f3)
      3'b000:  w_ld_val = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_ld_val = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_ld_val = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_ld_val = {56'd0, w_lane[7:0]};
      3'b101:  w_ld_val = {48'd0, w_lane[15:0]};
      3'b110:  w_ld_val = {32'd0, w_lane[31:0]};
      default: w_ld_val = w_lane;
    endcase
    case (w_a_f3[1:0])
      2'b00:   w_smask = 64'h0000_0000_0000_00FF;
      2'b01:   w_smask = 64'h0000_0000_0000_FFFF;
      2'b10:   w_smask = 64'h0000_0000_FFFF_FFFF;
      default: w_smask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    w_bmask = w_smask << w_sh;
    w_new   = (w_old & ~w_bmask) | ((w_a_wdata << w_sh) & w_bmask);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_nxt = DIRECT ? RESP : ACCESS;
      ACCESS:  if (w_cnt_done) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_state_nxt == RESP);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_fault_nxt = w_ready_nxt & ((r_state == IDLE) ? w_req_flt : r_flt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready    <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      readdata <= 64'd0;
      r_cnt    <= CW'(0);
      r_addr   <= 64'd0;
      r_wdata  <= 64'd0;
      r_f3     <= 3'd0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_flt    <= 1'b0;
    end else begin
      ready <= w_ready_nxt;
      busy  <= w_busy_nxt;
      fault <= w_fault_nxt;
      if (w_accept) begin
        r_cnt   <= CW'(WAIT);
        r_addr  <= address;
        r_wdata <= writedata;
        r_f3    <= funct3;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
        r_flt   <= w_req_flt;
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_ld_en) readdata <= w_ld_val;
    end
  end

  // Backing store is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_st_en) r_mem[w_idx] <= w_new;
  end

endmodule
